ts_gen_ml: RTL
==============

Name: ts_gen_ml

Overview:
- Multi-lane, parametrised training-set generator; successor to the single-lane TS sender.
- Sits between the LTSSM FSM/TSA and the per-lane TX FIFOs.
- Builds one 16-symbol TS1/TS2 per lane with per-lane lane numbers, optional lane reversal and link-number override.
- Transmits in lockstep across lanes, counts TSs sent against a programmable target, and honours an explicit stop.

Parameters:
- NUM_LANES, 4, number of lanes, 1..16.
- CNT_W, 16, width of the sent counter and target.
- RATE_SUPPORT, 6'b000001, value placed in symbol 4 bits [5:0].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ts_update  in  1  FSM request to load new TS content and restart counting.
- ts_update_ack  out  1  one-cycle ack of ts_update.
- ts_stop  in  1  stop transmission and return to IDLE.
- ts_type  in  1  0 = TS1 (ident 8'h4A), 1 = TS2 (ident 8'h45).
- link_num  in  8  link number to send when link_vld is set.
- link_vld  in  1  1 = send link_num, 0 = send PAD.
- lane_vld  in  1  1 = send per-lane numbers, 0 = send PAD.
- lane_rev  in  1  1 = lane i sends number NUM_LANES-1-i.
- tsa_update  in  1  TSA request to change link/lane fields without resetting the count.
- tsa_update_ack  out  1  one-cycle ack of tsa_update.
- target  in  CNT_W  number of TSs to send before sent_enough.
- sent_enough  out  1  sticky; count has reached target.
- ts_valid  out  NUM_LANES  per-lane TS valid; all bits are always equal.
- ts  out  128*NUM_LANES  lane i occupies [128*i+127 : 128*i]; symbol 0 in the MSBs.
- fifo_full  in  NUM_LANES  per-lane TX FIFO full.

Behaviour:
- Reset: state IDLE, count 0, all symbol registers 0, and all outputs 0.
- Symbol map per lane:
  - sym0 = COM 8'hBC.
  - sym1 = link_vld ? link_num : PAD 8'hF7.
  - sym2 = lane_vld ? lane number : 8'hF7.
  - sym3 = 8'hFF.
  - sym4 = {2'b00, RATE_SUPPORT}.
  - sym5 = 8'h00.
  - sym6..15 = ident selected by ts_type.
- Inputs are sampled only on a load or a field update; stored fields are stable while sending.
- States: IDLE, LOAD, SEND.
- IDLE:
  - ts_valid = 0.
  - ts_update -> LOAD: latch all fields and target, pulse ts_update_ack next cycle, clear count and sent_enough.
  - tsa_update in IDLE is acked and its fields latched; the state stays IDLE.
- LOAD:
  - One cycle; the registered symbols become visible.
  - -> SEND.
  - ts_valid is first asserted in the cycle after LOAD (latency 2 from ts_update).
- SEND:
  - Lockstep: ts_valid = all lanes not full (~|fifo_full), registered.
  - If any lane is full, ts_valid = 0 on every lane.
  - Count increments by 1 on each cycle ts_valid is high.
  - Count saturates at all-ones; it never wraps.
  - sent_enough is set the cycle after count >= target and stays set until the next load or reset.
  - target = 0 sets sent_enough the cycle after LOAD.
- Field update in SEND:
  - tsa_update latches link/lane fields and pulses tsa_update_ack.
  - New symbols apply from the next ts beat.
  - Count and sent_enough are kept.
- ts_update in SEND:
  - Acts as a load, same as from IDLE: -> LOAD.
  - ts_valid is 0 for that LOAD cycle.
  - It is ignored while ts_update_ack is high (no double-ack on a held request).
- ts_stop:
  - From any state -> IDLE next cycle; ts_valid deasserts next cycle.
  - Count and sent_enough are held.
  - Highest priority: ts_stop, then ts_update, then tsa_update.
- Simultaneous ts_update and tsa_update:
  - Both acks pulse.
  - The tsa link/lane values win.
  - Count is cleared.
- rst mid-SEND: everything returns to reset values on the next edge; no partial TS is flagged valid.

Decomposition:
- Shared package/define file holds: COM, PAD, TS1_IDTFR, TS2_IDTFR, N_FTS 8'hFF, the state encodings, and a lane-field-width constant.
- Sub-module ts_lane_fmt: pure combinational builder from (link, lane, type) to a 128-bit TS; one instance per lane via generate.
- The top module holds the FSM, counter, acks and registers.

Test Plan:
1. NUM_LANES=4, ts_update with ts_type=0, link_vld=0, lane_vld=0, target=8 -> each lane ts = BC F7 F7 FF 01 00 then 10×4A; ts_update_ack one cycle; sent_enough set after the 8th valid beat.
2. link_num=8'h05, link_vld=1, lane_vld=1, lane_rev=0 then 1, ts_type=1 -> lane 0/1/2/3 sym2 = 00/01/02/03 and then 03/02/01/00; sym1 = 05; sym6..15 = 45.
3. SEND with target=4, fifo_full[2]=1 for 3 cycles -> ts_valid all 0 for those cycles; count frozen; sent_enough delayed by 3 cycles.
4. tsa_update changing link 05->07 at count 2, target=4 -> ack pulse; sym1=07 from the next beat; sent_enough after 2 more beats (no count reset).
5. ts_update held high 4 cycles during SEND -> exactly one ack; one LOAD; count restarts at 0.
6. ts_stop during SEND at count 3 -> ts_valid low next cycle; state IDLE; sent_enough still 0 with target=8. Then assert rst mid-SEND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ts_gen_ml_pkg.sv
// Shared constants and state encoding for the multi-lane training-set generator.
// Symbol values follow the PCIe TS1/TS2 ordered-set layout.
package ts_gen_ml_pkg;

  localparam logic [7:0] COM       = 8'hBC;
  localparam logic [7:0] PAD       = 8'hF7;
  localparam logic [7:0] TS1_IDTFR = 8'h4A;
  localparam logic [7:0] TS2_IDTFR = 8'h45;
  localparam logic [7:0] N_FTS     = 8'hFF;

  localparam int LANE_W = 8;
  localparam int TS_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } ts_state_t;

  function automatic logic [7:0] ts_ident(input logic ts_type);
    return ts_type ? TS2_IDTFR : TS1_IDTFR;
  endfunction

endpackage

// File: rtl/ts_lane_fmt.sv
// Combinational builder of one 16-symbol TS1/TS2 for a single lane.
// Symbol 0 is placed in the most significant byte.
module ts_lane_fmt
  import ts_gen_ml_pkg::*;
#(
  parameter logic [5:0] RATE_SUPPORT = 6'b000001
) (
  input  logic              i_link_vld,
  input  logic [7:0]        i_link_num,
  input  logic              i_lane_vld,
  input  logic [LANE_W-1:0] i_lane_num,
  input  logic              i_ts_type,
  output logic [TS_W-1:0]   o_ts
);

  logic [7:0] w_sym1;
  logic [7:0] w_sym2;
  logic [7:0] w_ident;

  assign w_sym1  = i_link_vld ? i_link_num : PAD;
  assign w_sym2  = i_lane_vld ? i_lane_num : PAD;
  assign w_ident = ts_ident(i_ts_type);

  assign o_ts = {COM, w_sym1, w_sym2, N_FTS, {2'b00, RATE_SUPPORT}, 8'h00,
                 {10{w_ident}}};

endmodule

// File: rtl/ts_gen_ml.sv
// Multi-lane TS generator: FSM, sent counter, acks and the registered per-lane TS.
// All lanes transmit in lockstep; any full FIFO stalls every lane.
module ts_gen_ml
  import ts_gen_ml_pkg::*;
#(
  parameter int         NUM_LANES    = 4,
  parameter int         CNT_W        = 16,
  parameter logic [5:0] RATE_SUPPORT = 6'b000001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ts_update,
  output logic                      ts_update_ack,
  input  logic                      ts_stop,
  input  logic                      ts_type,
  input  logic [7:0]                link_num,
  input  logic                      link_vld,
  input  logic                      lane_vld,
  input  logic                      lane_rev,
  input  logic                      tsa_update,
  output logic                      tsa_update_ack,
  input  logic [CNT_W-1:0]          target,
  output logic                      sent_enough,
  output logic [NUM_LANES-1:0]      ts_valid,
  output logic [TS_W*NUM_LANES-1:0] ts,
  input  logic [NUM_LANES-1:0]      fifo_full
);

  ts_state_t r_state;
  ts_state_t w_state_nxt;

  logic                      r_upd_hold;
  logic                      r_ts_ack;
  logic                      r_tsa_ack;
  logic                      r_valid;
  logic                      r_sent;
  logic                      r_ts_type;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          r_target;
  logic [TS_W*NUM_LANES-1:0] r_ts;

  logic                      w_load;
  logic                      w_fld;
  logic                      w_type_sel;
  logic                      w_cnt_max;
  logic [TS_W*NUM_LANES-1:0] w_ts_bld;

  // A held ts_update is accepted once; it must drop before it can load again.
  assign w_load     = ts_update & ~r_upd_hold & ~ts_stop;
  assign w_fld      = tsa_update & ~ts_stop;
  assign w_type_sel = w_load ? ts_type : r_ts_type;
  assign w_cnt_max  = (r_cnt == {CNT_W{1'b1}});

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [LANE_W-1:0] LN_FWD = LANE_W'(g);
    localparam logic [LANE_W-1:0] LN_REV = LANE_W'(NUM_LANES - 1 - g);

    logic [LANE_W-1:0] w_lane_num;

    assign w_lane_num = lane_rev ? LN_REV : LN_FWD;

    ts_lane_fmt #(
      .RATE_SUPPORT(RATE_SUPPORT)
    ) u_fmt (
      .i_link_vld(link_vld),
      .i_link_num(link_num),
      .i_lane_vld(lane_vld),
      .i_lane_num(w_lane_num),
      .i_ts_type (w_type_sel),
      .o_ts      (w_ts_bld[TS_W*g +: TS_W])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ts_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_load) begin
      w_state_nxt = ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_LOAD: w_state_nxt = ST_SEND;
        ST_SEND: w_state_nxt = ST_SEND;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_upd_hold <= 1'b0;
      r_ts_ack   <= 1'b0;
      r_tsa_ack  <= 1'b0;
      r_valid    <= 1'b0;
      r_sent     <= 1'b0;
      r_ts_type  <= 1'b0;
      r_cnt      <= '0;
      r_target   <= '0;
      r_ts       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_upd_hold <= w_load | (r_upd_hold & ts_update);
      r_ts_ack   <= w_load;
      r_tsa_ack  <= w_fld;
      r_valid    <= (w_state_nxt == ST_SEND) & ~|fifo_full;

      if (w_load | w_fld) begin
        r_ts <= w_ts_bld;
      end
      if (w_load) begin
        r_ts_type <= ts_type;
        r_target  <= target;
      end

      // The beat presented this cycle is counted even if a stop arrives with it.
      if (w_load) begin
        r_cnt <= '0;
      end else if (r_valid && !w_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_load) begin
        r_sent <= 1'b0;
      end else if (!ts_stop && r_state != ST_IDLE && r_cnt >= r_target) begin
        r_sent <= 1'b1;
      end
    end
  end

  assign ts_update_ack  = r_ts_ack;
  assign tsa_update_ack = r_tsa_ack;
  assign sent_enough    = r_sent;
  assign ts_valid       = {NUM_LANES{r_valid}};
  assign ts             = r_ts;

endmodule
